// File: rtl/systolic_share_ctrl.sv
// systolic_share_ctrl
//   Sequencer and round-robin arbiter that lets NREQ Kalman-filter stages
//   share one 12x12 systolic array. One owner at a time: the winner's index
//   drives the array operand muxes (sel), its mode bits are latched into the
//   array enables, load_en is pulsed once, and the controller waits for
//   cal_finish (or a watchdog expiry) before pulsing done to the owner.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req[NREQ]         level requests, held until done
//   req_mode[NREQ][3] per-requester {enb_7_12, enb_2_6, enb_1}
//   grant[NREQ]       one-hot owner (SETUP..FIN)
//   sel[SELW]         binary owner index, held after FIN
//   sa_load_en        one-cycle array load strobe (LOAD state)
//   sa_enb_*          latched array enables for the owner
//   sa_cal_finish     array completion, only sampled in RUN
//   done[NREQ]        one-cycle completion pulse to the owner
//   busy              high in every state but IDLE
//   timeout_err       sticky watchdog flag, cleared only by rst
module systolic_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int SELW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0][2:0] req_mode,
  output logic [NREQ-1:0]      grant,
  output logic [SELW-1:0]      sel,
  output logic                 sa_load_en,
  output logic                 sa_enb_1,
  output logic                 sa_enb_2_6,
  output logic                 sa_enb_7_12,
  input  logic                 sa_cal_finish,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_RUN, S_FIN
  } state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [CNTW-1:0] cnt;
  logic            found;
  logic [SELW-1:0] win;
  logic [SELW-1:0] cand;
  logic [SELW-1:0] ptr_nxt;
  int unsigned     idx;

  // Round-robin pick: first set request bit searching upward from ptr,
  // wrapping modulo NREQ. Only consumed in IDLE, so the result is registered
  // before it reaches grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = (int'(ptr) + i) % NREQ;
      cand = idx[SELW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next pointer is one past the owner, wrapping for non power-of-two NREQ.
  assign ptr_nxt = (sel == SELW'(NREQ - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      sel         <= '0;
      sa_load_en  <= 1'b0;
      sa_enb_1    <= 1'b0;
      sa_enb_2_6  <= 1'b0;
      sa_enb_7_12 <= 1'b0;
      done        <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Strobes default low; each state re-asserts what it owns.
      done       <= '0;
      sa_load_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            sel   <= win;
            // Mode is captured once here; later req_mode edits are ignored.
            {sa_enb_7_12, sa_enb_2_6, sa_enb_1} <= req_mode[win];
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Operand muxes settle this cycle; load strobe lands in LOAD.
          sa_load_en <= 1'b1;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          // Completion takes priority over a same-cycle watchdog expiry.
          if (sa_cal_finish) begin
            done  <= grant;
            state <= S_FIN;
          end else if (cnt == CNTW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            done        <= grant;
            state       <= S_FIN;
          end
        end
        S_FIN: begin
          ptr         <= ptr_nxt;
          grant       <= '0;
          sa_enb_1    <= 1'b0;
          sa_enb_2_6  <= 1'b0;
          sa_enb_7_12 <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_share_ctrl.sv
module tb_systolic_share_ctrl;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0][2:0] req_mode;
  logic [NREQ-1:0]      grant;
  logic [SELW-1:0]      sel;
  logic                 sa_load_en, sa_enb_1, sa_enb_2_6, sa_enb_7_12;
  logic                 sa_cal_finish;
  logic [NREQ-1:0]      done;
  logic                 busy, timeout_err;

  int checks = 0;
  int errors = 0;

  systolic_share_ctrl #(.NREQ(NREQ), .TIMEOUT(64), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode),
    .grant(grant), .sel(sel), .sa_load_en(sa_load_en),
    .sa_enb_1(sa_enb_1), .sa_enb_2_6(sa_enb_2_6), .sa_enb_7_12(sa_enb_7_12),
    .sa_cal_finish(sa_cal_finish), .done(done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  wire [2:0] enb = {sa_enb_7_12, sa_enb_2_6, sa_enb_1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, 32'(grant), 0);
    chk({tag, " load_en"}, 32'(sa_load_en), 0);
    chk({tag, " enb"}, 32'(enb), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  // Reset pulse; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_idle("rst");
    chk("rst sel", 32'(sel), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    tick();
    rst = 1'b0;
  endtask

  // One full operation starting from a visible IDLE with req already set.
  // fin==0: cal_finish never arrives. fin==k: cal_finish on the k-th cycle
  // after the load_en cycle. drop: owner releases req and edits its mode in RUN.
  task automatic op(input int who, input logic [2:0] mode, input int fin,
                    input logic drop, input logic exp_to);
    logic [3:0] g;
    g = 4'(1 << who);
    tick();                                   // SETUP
    chk("setup grant", 32'(grant), 32'(g));
    chk("setup sel", 32'(sel), 32'(who));
    chk("setup enb", 32'(enb), 32'(mode));
    chk("setup busy", 32'(busy), 1);
    chk("setup load_en", 32'(sa_load_en), 0);
    tick();                                   // LOAD
    chk("load load_en", 32'(sa_load_en), 1);
    tick();                                   // first RUN cycle
    chk("run load_en", 32'(sa_load_en), 0);
    if (drop) begin
      req[who]      = 1'b0;
      req_mode[who] = ~mode;
    end
    if (fin == 0) begin
      repeat (63) tick();
      chk("pre-timeout done", 32'(done), 0);
      tick();
    end else begin
      repeat (fin - 1) tick();
      chk("pre-finish done", 32'(done), 0);
      sa_cal_finish = 1'b1;
      tick();
      sa_cal_finish = 1'b0;
    end
    chk("fin done", 32'(done), 32'(g));
    chk("fin grant", 32'(grant), 32'(g));
    chk("fin enb", 32'(enb), 32'(mode));
    chk("fin timeout_err", 32'(timeout_err), 32'(exp_to));
    tick();                                   // IDLE
    chk_idle("post");
    chk("post sel hold", 32'(sel), 32'(who));
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    sa_cal_finish = 1'b0;
    req_mode[0] = 3'b001;
    req_mode[1] = 3'b010;
    req_mode[2] = 3'b100;
    req_mode[3] = 3'b111;
    do_reset();

    // Single request
    req = 4'b0001;
    op(0, 3'b001, 12, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    chk_idle("single idle");

    // Contention: all requesters held, expect 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    op(0, 3'b001, 12, 1'b0, 1'b0);
    op(1, 3'b010, 12, 1'b0, 1'b0);
    op(2, 3'b100, 12, 1'b0, 1'b0);
    op(3, 3'b111, 12, 1'b0, 1'b0);
    op(0, 3'b001, 12, 1'b0, 1'b0);
    req = 4'b0000;
    tick();

    // Watchdog, then a normal op with the sticky flag still set
    do_reset();
    req = 4'b0100;
    op(2, 3'b100, 0, 1'b0, 1'b1);
    req = 4'b0001;
    op(0, 3'b001, 12, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    chk("sticky timeout_err", 32'(timeout_err), 1);

    // Coincidence: cal_finish on the last RUN cycle (counter 63)
    do_reset();
    req = 4'b0001;
    op(0, 3'b001, 64, 1'b0, 1'b0);
    req = 4'b0000;

    // Early drop with a mode change during RUN; pointer is now 1
    req_mode[1] = 3'b110;
    req = 4'b0010;
    op(1, 3'b110, 12, 1'b1, 1'b0);
    repeat (3) tick();
    chk_idle("no regrant");

    // Reset mid-RUN; pointer is now 2
    req = 4'b0100;
    repeat (5) tick();                        // SETUP, LOAD, RUN x3
    chk("midrun busy", 32'(busy), 1);
    chk("midrun grant", 32'(grant), 32'(4'b0100));
    #3;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk_idle("async rst");
    chk("async rst sel", 32'(sel), 0);
    repeat (2) begin
      tick();
      chk("rst no done", 32'(done), 0);
    end
    rst = 1'b0;
    tick();
    req = 4'b0110;                            // pointer 0 must pick requester 1
    tick();
    chk("post-rst grant", 32'(grant), 32'(4'b0010));
    chk("post-rst sel", 32'(sel), 1);
    req = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
